regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the RV32I pipeline, successor to the single-write, two-read register file. Adds configurable data width, depth and read-port count, two write ports, same-cycle write-to-read bypass, asynchronous clear of all entries, and a per-register pending (scoreboard) bit for hazard detection. Sits between decode (reads, issue marking) and writeback (writes, pending clear).

---
 rtl/regfile_scoreboard_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 tb/tb_regfile_scoreboard.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard_if
//  Description : Decode/writeback bus for the register file with scoreboard:
//                two write ports, issue marking, NUM_RD combinational reads.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [1:0]               wb_en;
    logic [2*ADDR_W-1:0]      wb_idx;
    logic [2*DATA_W-1:0]      wb_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_idx;
    logic [NUM_RD*ADDR_W-1:0] rd_idx;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     any_busy;

    // Pipeline side: drives writes, issues and read indices.
    modport master (
        output wb_en, wb_idx, wb_data, iss_en, iss_idx, rd_idx,
        input  rd_data, rd_busy, any_busy
    );

    // Register file side.
    modport slave (
        input  wb_en, wb_idx, wb_data, iss_en, iss_idx, rd_idx,
        output rd_data, rd_busy, any_busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Parametrised GPR file, two write ports (port 1 wins on
//                collision), write-to-read bypass, per-entry pending bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    regfile_scoreboard_if.slave   bus
);
    localparam int c_DEPTH = 1 << ADDR_W;
    localparam bit c_ZERO  = (ZERO_REG != 0);

    logic [DATA_W-1:0]  mem_q [c_DEPTH];
    logic [DATA_W-1:0]  mem_d [c_DEPTH];
    logic [c_DEPTH-1:0] pend_q;
    logic [c_DEPTH-1:0] pend_d;

    logic [ADDR_W-1:0]  w_wb_idx  [2];
    logic [DATA_W-1:0]  w_wb_data [2];
    logic [1:0]         w_wb_legal;
    logic               w_iss_legal;

    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]        w_rd_busy;
    logic [ADDR_W-1:0]        w_rd_idx;

    // Unpack write ports; entry 0 is not a legal target when hardwired.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_wb_idx[k]   = bus.wb_idx[k*ADDR_W +: ADDR_W];
            w_wb_data[k]  = bus.wb_data[k*DATA_W +: DATA_W];
            w_wb_legal[k] = bus.wb_en[k] && !(c_ZERO && (w_wb_idx[k] == '0));
        end
        w_iss_legal = bus.iss_en && !(c_ZERO && (bus.iss_idx == '0));
    end

    // Next state: port 1 applied after port 0 so it wins; issue set last so a
    // newer producer overrides a same-cycle writeback clear.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        for (int k = 0; k < 2; k++) begin
            if (w_wb_legal[k]) begin
                mem_d[w_wb_idx[k]]  = w_wb_data[k];
                pend_d[w_wb_idx[k]] = 1'b0;
            end
        end
        if (w_iss_legal) begin
            pend_d[bus.iss_idx] = 1'b1;
        end
    end

    // State registers with asynchronous clear of every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Combinational reads: zero reg, then port 1 bypass, port 0 bypass, array.
    // Outputs forced to zero while reset is held so bypass cannot leak through.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        w_rd_idx  = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            w_rd_idx = bus.rd_idx[j*ADDR_W +: ADDR_W];
            if (!rst_n) begin
                w_rd_data[j*DATA_W +: DATA_W] = '0;
                w_rd_busy[j]                  = 1'b0;
            end else if (c_ZERO && (w_rd_idx == '0)) begin
                w_rd_data[j*DATA_W +: DATA_W] = '0;
                w_rd_busy[j]                  = 1'b0;
            end else if (bus.wb_en[1] && (w_wb_idx[1] == w_rd_idx)) begin
                w_rd_data[j*DATA_W +: DATA_W] = w_wb_data[1];
                w_rd_busy[j]                  = 1'b0;
            end else if (bus.wb_en[0] && (w_wb_idx[0] == w_rd_idx)) begin
                w_rd_data[j*DATA_W +: DATA_W] = w_wb_data[0];
                w_rd_busy[j]                  = 1'b0;
            end else begin
                w_rd_data[j*DATA_W +: DATA_W] = mem_q[w_rd_idx];
                w_rd_busy[j]                  = pend_q[w_rd_idx];
            end
        end
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_busy  = w_rd_busy;
    assign bus.any_busy = rst_n && (|pend_q);

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Self-checking bench: directed steps plus random traffic on
//                the default configuration, directed checks on a 64-bit,
//                16-entry, 3-read-port, no-zero-register configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifc ();
    regfile_scoreboard_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3)) pifc ();

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    regfile_scoreboard #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .bus(pifc.slave));

    // Reference model of the default instance: architectural register contents
    // and pending flags.
    logic [31:0] m_reg  [32];
    bit          m_pend [32];

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Apply the effect of the current inputs at a clock edge.
    task automatic model_update();
        logic [4:0]  idx;
        logic [31:0] dat;
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            idx = ifc.wb_idx[k*5 +: 5];
            dat = ifc.wb_data[k*32 +: 32];
            if (ifc.wb_en[k] && idx != 0) begin
                m_reg[idx]  = dat;
                m_pend[idx] = 1'b0;
            end
        end
        if (ifc.iss_en && ifc.iss_idx != 0) m_pend[ifc.iss_idx] = 1'b1;
    endtask

    task automatic model_read(input logic [4:0] idx, output logic [31:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (!rst_n || idx == 0) return;
        if (ifc.wb_en[1] && ifc.wb_idx[9:5] == idx) begin
            d = ifc.wb_data[63:32];
        end else if (ifc.wb_en[0] && ifc.wb_idx[4:0] == idx) begin
            d = ifc.wb_data[31:0];
        end else begin
            d = m_reg[idx];
            b = m_pend[idx];
        end
    endtask

    function automatic logic model_any();
        logic a = 1'b0;
        for (int i = 0; i < 32; i++) a |= m_pend[i];
        return rst_n && a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wen, input logic [4:0] i0, input logic [31:0] d0,
                         input logic [4:0] i1, input logic [31:0] d1, input logic iss,
                         input logic [4:0] ii, input logic [4:0] r0, input logic [4:0] r1);
        ifc.wb_en   = wen;
        ifc.wb_idx  = {i1, i0};
        ifc.wb_data = {d1, d0};
        ifc.iss_en  = iss;
        ifc.iss_idx = ii;
        ifc.rd_idx  = {r1, r0};
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] d;
        logic        b;
        for (int j = 0; j < 2; j++) begin
            model_read(ifc.rd_idx[j*5 +: 5], d, b);
            chk($sformatf("%s_rd%0d_data", tag, j), ifc.rd_data[j*32 +: 32], d);
            chk($sformatf("%s_rd%0d_busy", tag, j), ifc.rd_busy[j], b);
        end
        chk($sformatf("%s_any", tag), ifc.any_busy, model_any());
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        pifc.wb_en = '0; pifc.wb_idx = '0; pifc.wb_data = '0;
        pifc.iss_en = 1'b0; pifc.iss_idx = '0; pifc.rd_idx = '0;
        drive(2'b01, 5'd4, 32'hCAFEF00D, 5'd0, 0, 1'b1, 5'd4, 5'd4, 5'd4);
        chk("reset_rd_data", ifc.rd_data, 64'h0);
        chk("reset_rd_busy", ifc.rd_busy, 2'b00);
        chk("reset_any", ifc.any_busy, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd4, 5'd4);
        chk("post_reset_x4", ifc.rd_data[31:0], 32'h0);
        tick();

        // Plain write then read on both ports.
        drive(2'b01, 5'd3, 32'h12345678, 0, 0, 1'b0, 0, 0, 0);
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd3, 5'd3);
        chk("wr_x3_p0", ifc.rd_data[31:0], 32'h12345678);
        chk("wr_x3_p1", ifc.rd_data[63:32], 32'h12345678);
        chk("wr_x3_busy", ifc.rd_busy, 2'b00);
        // x0 stays zero.
        drive(2'b01, 5'd0, 32'hFFFFFFFF, 0, 0, 1'b0, 0, 5'd0, 5'd0);
        chk("x0_bypass_zero", ifc.rd_data[31:0], 32'h0);
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd0, 5'd3);
        chk("x0_stored_zero", ifc.rd_data[31:0], 32'h0);

        // Bypass: stored x7 old, same-cycle write visible.
        drive(2'b01, 5'd7, 32'h0BAD0000, 0, 0, 1'b0, 0, 0, 0);
        tick();
        drive(2'b01, 5'd7, 32'hA5A5A5A5, 0, 0, 1'b0, 0, 5'd7, 5'd3);
        chk("bypass_p0", ifc.rd_data[31:0], 32'hA5A5A5A5);
        chk("no_bypass_p1", ifc.rd_data[63:32], 32'h12345678);
        tick();
        drive(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 1'b0, 0, 5'd7, 5'd7);
        chk("collide_bypass", ifc.rd_data[31:0], 32'h2222);
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd7, 5'd7);
        chk("collide_stored", ifc.rd_data[63:32], 32'h2222);

        // Scoreboard set / writeback clear.
        drive(2'b00, 0, 0, 0, 0, 1'b1, 5'd9, 5'd9, 5'd9);
        chk("iss_same_cycle_busy", ifc.rd_busy, 2'b00);
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd9, 5'd3);
        chk("iss_busy", ifc.rd_busy, 2'b01);
        chk("iss_any", ifc.any_busy, 1'b1);
        drive(2'b01, 5'd9, 32'h55, 0, 0, 1'b0, 0, 5'd9, 5'd9);
        chk("wb_clear_busy", ifc.rd_busy, 2'b00);
        chk("wb_clear_data", ifc.rd_data[31:0], 32'h55);
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd9, 5'd9);
        chk("wb_clear_any", ifc.any_busy, 1'b0);

        // Set beats clear on the same index.
        drive(2'b10, 0, 0, 5'd9, 32'h77, 1'b1, 5'd9, 5'd9, 5'd9);
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd9, 5'd9);
        chk("race_data", ifc.rd_data[31:0], 32'h77);
        chk("race_busy", ifc.rd_busy, 2'b11);
        drive(2'b00, 0, 0, 0, 0, 1'b1, 5'd0, 5'd0, 5'd0);
        tick();
        check_model("iss_x0");

        // Asynchronous reset in the middle of operation.
        drive(2'b01, 5'd5, 32'hDEADBEEF, 0, 0, 1'b1, 5'd12, 0, 0);
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd5, 5'd12);
        chk("pre_rst_x5", ifc.rd_data[31:0], 32'hDEADBEEF);
        chk("pre_rst_any", ifc.any_busy, 1'b1);
        rst_n = 1'b0;
        model_clear();
        drive(2'b11, 5'd5, 32'h1, 5'd12, 32'h2, 1'b1, 5'd6, 5'd5, 5'd12);
        chk("in_rst_data", ifc.rd_data, 64'h0);
        chk("in_rst_busy", ifc.rd_busy, 2'b00);
        chk("in_rst_any", ifc.any_busy, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd5, 5'd6);
        chk("post_rst_x5", ifc.rd_data[31:0], 32'h0);
        check_model("post_rst");
        tick();

        // 64-bit, 16-entry, three read ports, entry 0 ordinary.
        pifc.wb_en   = 2'b11;
        pifc.wb_idx  = {4'd15, 4'd0};
        pifc.wb_data = {64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
        tick();
        pifc.wb_en  = 2'b00;
        pifc.rd_idx = {4'd0, 4'd0, 4'd0};
        #1;
        for (int j = 0; j < 3; j++)
            chk($sformatf("p64_x0_rd%0d", j), pifc.rd_data[j*64 +: 64], 64'h0123456789ABCDEF);
        pifc.rd_idx = {4'd15, 4'd15, 4'd15};
        #1;
        for (int j = 0; j < 3; j++)
            chk($sformatf("p64_x15_rd%0d", j), pifc.rd_data[j*64 +: 64], 64'h0123456789ABCDEF);
        pifc.iss_en  = 1'b1;
        pifc.iss_idx = 4'd0;
        tick();
        pifc.iss_en = 1'b0;
        pifc.rd_idx = {4'd0, 4'd15, 4'd0};
        #1;
        chk("p64_x0_busy", pifc.rd_busy, 3'b101);
        chk("p64_any", pifc.any_busy, 1'b1);

        // Random traffic concentrated on a few registers to force collisions.
        for (int n = 0; n < 400; n++) begin
            drive(2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            check_model("rnd");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
